// File: rtl/fetch_stage_if.sv
// Instruction-memory request channel between the fetch stage and the instruction memory.
// A word moves when req and ack are both high in the same cycle; rdata is valid in that cycle.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, fetches over the imem channel, fills IF/ID,
// parks one word while the hazard unit stalls, and applies execute-stage redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_brc_pc_sel,
    input  logic [31:0] i_pc_br,
    input  logic        i_stall,
    fetch_stage_if.master imem,
    output logic [31:0] o_pc_cur,
    output logic [31:0] o_pc_four,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic        o_fsm_state
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        transfer;
    logic        unused_br_bits;

    // The request drops with reset itself so an in-flight fetch is abandoned at once.
    assign imem.req       = i_rst_n & (state_q == FETCH);
    assign imem.addr      = {pc_q[31:2], 2'b00};
    assign transfer       = imem.req & imem.ack;
    assign unused_br_bits = ^i_pc_br[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            hold_pc_q    <= 32'h0000_0000;
            hold_instr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        // A redirect beats stall, ack and state; a word landing this cycle is dropped.
        if (i_brc_pc_sel) begin
            pc_d         = {i_pc_br[31:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            state_d      = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (transfer) begin
                        pc_d = pc_q + 32'd4;
                        if (i_stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem.rdata;
                            state_d      = HOLD;
                        end else begin
                            ifid_pc_d    = pc_q;
                            ifid_instr_d = imem.rdata;
                            ifid_valid_d = 1'b1;
                        end
                    end else if (!i_stall) begin
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        ifid_pc_d    = hold_pc_q;
                        ifid_instr_d = hold_instr_q;
                        ifid_valid_d = 1'b1;
                        state_d      = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign o_pc_cur    = ifid_pc_q;
    assign o_pc_four   = ifid_pc_q + 32'd4;
    assign o_instr     = ifid_instr_q;
    assign o_valid     = ifid_valid_q;
    assign o_fsm_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle control expectations plus an instruction
// queue popped whenever IF/ID presents a freshly loaded valid instruction.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic F = 1'b0;
  localparam logic H = 1'b1;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        state;
    logic        rst_chk;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        brc;
  logic [31:0] pc_br;
  logic        stall;
  logic [31:0] pc_cur;
  logic [31:0] pc_four;
  logic [31:0] instr;
  logic        valid;
  logic        fsm_state;
  logic        done;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;

  cyc_t        cyc_q[$];
  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  fetch_stage_if u_if ();

  fetch_stage u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_brc_pc_sel (brc),
    .i_pc_br      (pc_br),
    .i_stall      (stall),
    .imem         (u_if),
    .o_pc_cur     (pc_cur),
    .o_pc_four    (pc_four),
    .o_instr      (instr),
    .o_valid      (valid),
    .o_fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    prev_stall <= stall;
    prev_redir <= brc;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 ^ a;
  endfunction

  // driver: one call = one clock cycle of inputs plus its expectations
  task automatic step(input logic ack, input logic stl, input logic rd, input logic [31:0] br,
                      input logic ereq, input logic [31:0] eaddr, input logic evalid,
                      input logic est, input logic dlv, input logic rchk);
    u_if.ack   = ack;
    u_if.rdata = word(eaddr);
    stall      = stl;
    brc        = rd;
    pc_br      = br;
    cyc_q.push_back({ereq, eaddr, evalid, est, rchk});
    if (dlv) exp_q.push_back({eaddr, word(eaddr)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    brc        = 1'b0;
    pc_br      = 32'h0;
    stall      = 1'b0;
    u_if.ack   = 1'b0;
    u_if.rdata = 32'h0;
    done       = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, F, 0, 1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, F, 0, 1);
    rst_n = 1'b1;
    // sequential fetch with zero-wait memory
    step(1, 0, 0, 32'h0, 1, 32'h00, 0, F, 1, 0);
    step(1, 0, 0, 32'h0, 1, 32'h04, 1, F, 1, 0);
    // two wait states on 0x8
    step(0, 0, 0, 32'h0, 1, 32'h08, 1, F, 0, 0);
    step(0, 0, 0, 32'h0, 1, 32'h08, 0, F, 0, 0);
    step(1, 0, 0, 32'h0, 1, 32'h08, 0, F, 1, 0);
    step(1, 0, 0, 32'h0, 1, 32'h0C, 1, F, 1, 0);
    // three-cycle stall while 0x10 is acked
    step(1, 1, 0, 32'h0, 1, 32'h10, 1, F, 1, 0);
    step(0, 1, 0, 32'h0, 0, 32'h14, 1, H, 0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h14, 1, H, 0, 0);
    step(0, 0, 0, 32'h0, 0, 32'h14, 1, H, 0, 0);
    step(1, 0, 0, 32'h0, 1, 32'h14, 1, F, 1, 0);
    step(1, 0, 0, 32'h0, 1, 32'h18, 1, F, 1, 0);
    step(1, 0, 0, 32'h0, 1, 32'h1C, 1, F, 1, 0);
    // redirect to 0x103 while 0x20 is acked
    step(1, 0, 1, 32'h103, 1, 32'h20, 1, F, 0, 0);
    step(1, 0, 0, 32'h0, 1, 32'h100, 0, F, 1, 0);
    step(1, 0, 0, 32'h0, 1, 32'h104, 1, F, 1, 0);
    // redirect together with stall while holding 0x108
    step(1, 1, 0, 32'h0, 1, 32'h108, 1, F, 0, 0);
    step(0, 1, 1, 32'h200, 0, 32'h10C, 1, H, 0, 0);
    step(1, 0, 0, 32'h0, 1, 32'h200, 0, F, 1, 0);
    // reset in the middle of HOLD drops the parked 0x204
    step(1, 1, 0, 32'h0, 1, 32'h204, 1, F, 0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h208, 1, H, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, F, 0, 1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, F, 0, 1);
    rst_n = 1'b1;
    step(1, 0, 0, 32'h0, 1, 32'h0, 0, F, 1, 0);
    step(0, 0, 0, 32'h0, 1, 32'h4, 1, F, 0, 0);
    // unaligned redirect near the top of memory, then PC wrap to 0
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h4, 0, F, 0, 0);
    step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, F, 1, 0);
    step(0, 0, 0, 32'h0, 1, 32'h0, 1, F, 0, 0);
    step(0, 0, 0, 32'h0, 1, 32'h0, 0, F, 0, 0);
    done = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor and final report
  initial begin
    int          n;
    cyc_t        c;
    logic [63:0] e;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("imem_req", {31'h0, u_if.req}, {31'h0, c.req});
        check("imem_addr", u_if.addr, c.addr);
        check("valid", {31'h0, valid}, {31'h0, c.valid});
        check("fsm_state", {31'h0, fsm_state}, {31'h0, c.state});
        if (c.rst_chk) begin
          check("reset_pc_cur", pc_cur, 32'h0);
          check("reset_instr", instr, NOP);
          check("reset_pc_four", pc_four, 32'h4);
        end
        if (valid && !prev_stall && !prev_redir) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid_pc", pc_cur, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc", pc_cur, e[63:32]);
            check("ifid_instr", instr, e[31:0]);
            check("pc_four", pc_four, e[63:32] + 32'd4);
          end
        end
      end
    end
    check("stimulus_finished", {31'h0, done}, 32'h1);
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
